// File: rtl/bin2bcd_pkg.sv
// Shared constants, state encodings and saturation pattern for the binary-to-BCD converter.
// Optional macro BIN2BCD_AUTO_EN is consumed by bin2bcd_seq, not by this package.
package bin2bcd_pkg;

    localparam int BCD_NIB_W  = 4;
    localparam int INT_DIGITS = 10;
    localparam int ACC_W      = BCD_NIB_W * INT_DIGITS;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DONE  = 2'd2;

    function automatic logic [ACC_W-1:0] sat_pattern();
        return {INT_DIGITS{4'h9}};
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction for one BCD nibble ahead of a left shift.
// Latency 0; no flow control.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_NIB_W-1:0] din,
    output logic [BCD_NIB_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter; start sampled in IDLE only, no queueing.
// Latency IN_W+1 cycles start-to-done; bcd_out/ovf held between conversions. Macro: BIN2BCD_AUTO_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DIGITS = 8     // 1..INT_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(IN_W) + 1;
    localparam int OUT_W = BCD_NIB_W * DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
    localparam logic [ACC_W-1:0] SAT      = sat_pattern();

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IN_W-1:0]    shreg;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf_next;
    logic               accept;

    for (genvar g = 0; g < INT_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc[g*BCD_NIB_W +: BCD_NIB_W]),
            .dout (acc_adj[g*BCD_NIB_W +: BCD_NIB_W])
        );
    end

    assign acc_next = {acc_adj[ACC_W-2:0], shreg[IN_W-1]};
    // A carry out of the internal accumulator is also an overflow.
    assign ovf_next = (|(acc_next >> OUT_W)) | acc_adj[ACC_W-1];
    assign busy     = (state != IDLE);

`ifdef BIN2BCD_AUTO_EN
    logic [IN_W-1:0] last_bin;

    assign accept = start | (bin_in != last_bin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_bin <= '0;
        end else if (state == IDLE && accept) begin
            last_bin <= bin_in;
        end
    end
`else
    assign accept = start;
`endif

    // Result registers are loaded on the final shift so they become visible
    // together with done in the DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            acc     <= '0;
            done    <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= bin_in;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc   <= acc_next;
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        ovf     <= ovf_next;
                        bcd_out <= ovf_next ? SAT[OUT_W-1:0] : acc_next[OUT_W-1:0];
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
